// File: rtl/dice_pkg.sv
// Shared types, pip pattern table and decode helper for the eight-sided LED die.
package dice_pkg;

    localparam int unsigned DICE_W = 3;
    localparam int unsigned LED_W  = 9;

    typedef logic [DICE_W-1:0] dice_val_t;
    typedef logic [LED_W-1:0]  led_grid_t;

    // Row-major 3x3 grid, bit 4 is the centre; entry s lights s+1 pips.
    localparam led_grid_t PIP_PATTERN [0:7] = '{
        9'h010, 9'h101, 9'h111, 9'h145,
        9'h155, 9'h16D, 9'h17D, 9'h1EF
    };

    function automatic led_grid_t pips_to_led(input dice_val_t v);
        return PIP_PATTERN[v];
    endfunction

endpackage

// File: rtl/eight_dice_if.sv
// Value/roll request and LED/value display bundle for the eight-sided die.
interface eight_dice_if;
    import dice_pkg::*;

    dice_val_t s;
    logic      roll;
    led_grid_t out;
    dice_val_t value;

    modport master (output s, output roll, input out, input value);
    modport slave  (input s, input roll, output out, output value);

endinterface

// File: rtl/dice_roll_counter.sv
// Free-running 3-bit roll counter: advances while enabled, wraps 7->0, holds otherwise.
module dice_roll_counter
    import dice_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    output dice_val_t count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + DICE_W'(1);
        end
    end

endmodule

// File: rtl/eight_dice.sv
// Registered dice-value to 3x3 pip decoder with an internal roll counter source.
module eight_dice
    import dice_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    eight_dice_if.slave  bus
);

    // All-off panel level, which depends on the LED drive polarity.
    localparam led_grid_t LED_OFF = ACTIVE_LOW ? '1 : '0;

    dice_val_t count;
    dice_val_t sel_c;
    led_grid_t led_c;

    dice_roll_counter u_roll (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.roll),
        .count (count)
    );

    always_comb begin
        sel_c = bus.s;
        if (bus.roll) begin
            sel_c = count;
        end
        led_c = pips_to_led(sel_c) ^ {LED_W{ACTIVE_LOW}};
    end

    // Pattern and value are captured together so the panel never shows a mixed state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.value <= '0;
            bus.out   <= LED_OFF;
        end else begin
            bus.value <= sel_c;
            bus.out   <= led_c;
        end
    end

endmodule

// File: tb/tb_eight_dice.sv
// Directed bench for eight_dice covering both LED polarities.
module tb_eight_dice;
    import dice_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [8:0] exp_tab [8];

    eight_dice_if bus0 ();
    eight_dice_if bus1 ();

    eight_dice #(.ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    eight_dice #(.ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [2:0] sv, input logic rv);
        bus0.s = sv; bus0.roll = rv;
        bus1.s = sv; bus1.roll = rv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Leave a non-zero display, then assert reset away from any edge.
        set_in(3'd6, 1'b0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus0.out !== 9'h000) begin
            failures++; $display("FAIL reset_out got=%h exp=%h", bus0.out, 9'h000);
        end
        checks++;
        if (bus0.value !== 3'd0) begin
            failures++; $display("FAIL reset_value got=%0d exp=0", bus0.value);
        end
        checks++;
        if (bus1.out !== 9'h1FF) begin
            failures++; $display("FAIL reset_out_al got=%h exp=%h", bus1.out, 9'h1FF);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) begin
            set_in(3'(i), 1'b0);
            #1;
            if (i > 0) begin
                checks++;
                if (bus0.out !== exp_tab[i-1]) begin
                    failures++; $display("FAIL sweep_latency s=%0d got=%h exp=%h", i, bus0.out, exp_tab[i-1]);
                end
            end
            tick();
            checks++;
            if (bus0.out !== exp_tab[i] || bus0.value !== 3'(i)) begin
                failures++; $display("FAIL sweep s=%0d got=%h/%0d exp=%h/%0d", i, bus0.out, bus0.value, exp_tab[i], i);
            end
            checks++;
            if (bus1.out !== ~exp_tab[i]) begin
                failures++; $display("FAIL sweep_al s=%0d got=%h exp=%h", i, bus1.out, ~exp_tab[i]);
            end
        end
    endtask

    task automatic test_roll_wrap();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        set_in(3'd4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus0.value !== 3'(i % 8) || bus0.out !== exp_tab[i % 8]) begin
                failures++; $display("FAIL roll_wrap step=%0d got=%h/%0d exp=%h/%0d", i, bus0.out, bus0.value, exp_tab[i % 8], i % 8);
            end
        end
    endtask

    task automatic test_freeze_resume();
        // Counter is at 2 after the wrap run.
        @(negedge clk);
        set_in(3'd5, 1'b0);
        tick();
        checks++;
        if (bus0.out !== 9'h16D || bus0.value !== 3'd5) begin
            failures++; $display("FAIL freeze_show_s got=%h/%0d exp=16d/5", bus0.out, bus0.value);
        end
        tick();
        @(negedge clk);
        set_in(3'd5, 1'b1);
        tick();
        checks++;
        if (bus0.value !== 3'd2 || bus0.out !== 9'h111) begin
            failures++; $display("FAIL resume got=%h/%0d exp=111/2", bus0.out, bus0.value);
        end
        tick();
        checks++;
        if (bus0.value !== 3'd3) begin
            failures++; $display("FAIL resume_next got=%0d exp=3", bus0.value);
        end
    endtask

    task automatic test_reset_mid_roll();
        tick();
        checks++;
        if (bus0.value !== 3'd4) begin
            failures++; $display("FAIL mid_roll_pre got=%0d exp=4", bus0.value);
        end
        // Counter now holds 5.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus0.out !== 9'h000 || bus0.value !== 3'd0 || bus1.out !== 9'h1FF) begin
            failures++; $display("FAIL mid_roll_clear got=%h/%0d/%h exp=000/0/1ff", bus0.out, bus0.value, bus1.out);
        end
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (bus0.value !== 3'd0 || bus0.out !== 9'h010) begin
            failures++; $display("FAIL mid_roll_restart got=%h/%0d exp=010/0", bus0.out, bus0.value);
        end
        tick();
        checks++;
        if (bus0.value !== 3'd1) begin
            failures++; $display("FAIL mid_roll_next got=%0d exp=1", bus0.value);
        end
    endtask

    task automatic test_active_low();
        @(negedge clk);
        set_in(3'd3, 1'b0);
        tick();
        checks++;
        if (bus1.out !== 9'h0BA || bus1.value !== 3'd3) begin
            failures++; $display("FAIL active_low got=%h/%0d exp=0ba/3", bus1.out, bus1.value);
        end
        checks++;
        if (bus0.out !== 9'h145) begin
            failures++; $display("FAIL active_high_s3 got=%h exp=145", bus0.out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_tab  = '{9'h010, 9'h101, 9'h111, 9'h145, 9'h155, 9'h16D, 9'h17D, 9'h1EF};
        rst = 1'b1;
        set_in(3'd0, 1'b0);
        #12;
        rst = 1'b0;
        test_reset();
        test_sweep();
        test_roll_wrap();
        test_freeze_resume();
        test_reset_mid_roll();
        test_active_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
